hex_scroller: RTL and testbench
===============================

# hex_scroller

Parametrised scrolling-message driver for the DE-series seven-segment bank. It is the successor to the fixed three-character lab display and sits between the board top level (switches, keys, CLOCK_50) and HEX0..HEX(N-1). The block holds a writable message of NUM_CHARS 3-bit character codes. It rotates that message across NUM_DIGITS displays, either on an internal tick or on a manual step, in either direction.

## Interface
- NUM_DIGITS, 6, number of HEX displays driven (1..8)
- NUM_CHARS, 8, message length in characters (2..16, need not equal NUM_DIGITS)
- TICK_DIV, 50_000_000, CLOCK_50 cycles per automatic advance (>=2)
- PW, $clog2(NUM_CHARS), pointer width (derived)
- CLOCK_50  in  1  system clock, all state on rising edge
- Resetn  in  1  asynchronous, active-low reset
- run  in  1  1 = automatic scrolling on tick; 0 = tick counter frozen
- dir  in  1  0 = scroll left (offset increments), 1 = scroll right (offset decrements)
- step  in  1  synchronous level; each 0->1 transition requests one advance
- load_en  in  1  write load_char into message slot load_idx this cycle
- load_idx  in  PW  message slot to write; values >= NUM_CHARS are ignored
- load_char  in  3  character code: 0 d, 1 E, 2 1, 3 0, 4 H, 5 L, 6 P, 7 blank
- HEX  out  7*NUM_DIGITS  active-low segments, HEX[7k+6:7k] = display k, bit0 = seg a … bit6 = seg g
- pos  out  PW  current offset (message index shown on leftmost display)
- wrap  out  1  one-cycle pulse when the offset wraps

## Operation
- Message store: NUM_CHARS x 3-bit registers. Reset contents: slot0 = d, slot1 = E, slot2 = 1, all others blank.
- Display mapping: display k (k=0 rightmost) shows msg[(pos + NUM_DIGITS-1-k) mod NUM_CHARS]. The leftmost display therefore shows msg[pos].
- Segment encoding (active-low, hex of bits 6..0): d 21, E 06, 1 79, 0 40, H 09, L 47, P 0C, blank 7F.
- Tick counter: counts 0..TICK_DIV-1 while run=1 and holds while run=0. On the cycle it equals TICK_DIV-1 with run=1, it asserts tick and returns to 0.
- Step detect: a registered copy of step; step_rise = step & ~step_q.
- Advance = tick | step_rise. If both occur in the same cycle, the offset moves by exactly one position.
- Left advance: pos <= (pos == NUM_CHARS-1) ? 0 : pos+1. Right advance: pos <= (pos == 0) ? NUM_CHARS-1 : pos-1.
- wrap is asserted in the cycle after an advance that crossed NUM_CHARS-1 -> 0 (left) or 0 -> NUM_CHARS-1 (right).
- Load: when load_en is set and load_idx < NUM_CHARS, msg[load_idx] <= load_char. A load in the same cycle as an advance performs both. The display then reflects the new pos and the new character.
- Changing dir takes effect at the next advance. Deasserting run mid-count holds the counter value, so scrolling resumes without restarting the interval.

## Timing
- Reset (asynchronous assert) sets: HEX = all ones (all blank), pos = 0, wrap = 0, tick counter = 0, step_q = 0, message = reset contents.
- HEX is a registered output computed from the pos and msg register values.
  - The first rising edge after Resetn deasserts loads HEX with the reset message: display5..0 = d E 1 blank blank blank with the defaults.
- Advance latency: the pos update occurs on edge N (the cycle in which the tick or step_rise is seen). The HEX and wrap updates occur on edge N+1.
- Load latency: the msg update occurs on edge N; the HEX update occurs on edge N+1.
- Automatic interval: with run held at 1 from reset release, tick occurs in cycle TICK_DIV-1. Subsequent ticks follow every TICK_DIV cycles.
- step held high produces a single advance. It must return low for at least one cycle before re-arming.
- If reset is asserted mid-operation, it overrides everything immediately; no partial state is retained.

## Test plan
- Reset/idle: Resetn low then high with run=0. HEX = 7F for all digits during reset. One edge after release: HEX5..0 = 21 06 79 7F 7F 7F, pos = 0, and the outputs stay stable for 100 cycles.
- Auto left scroll (TICK_DIV=4): run=1, dir=0. pos steps 1,2,…,7,0 every 4 cycles. wrap pulses for exactly one cycle after 7->0. After the first advance, HEX5 = 06 (E).
- Right scroll and wrap: dir=1 from pos=0, then one step pulse. pos = 7, wrap pulses once, and HEX5 = 7F while HEX4 = 21.
- Step plus tick collision: step rises in the same cycle as the tick. pos advances by exactly 1. step held high for 10 cycles gives no further advances.
- Load during run: with run=1, write load_idx=3, load_char=4 (H) in the same cycle as an advance. Next edge: msg[3] = H and the display reflects both the new pos and the H (09). A write with load_idx=9 changes nothing.
- Freeze and resume: run=0 at counter value 2 for 20 cycles; pos is unchanged. After run=1 is restored, the next advance occurs 2 cycles later.

Source files
------------

// File: rtl/hex_scroller_if.sv
`default_nettype none
//==============================================================================
// Module   : hex_scroller_if
// Brief    : Control, message-load and display bundle for hex_scroller.
// Revision : 1.0
//==============================================================================
interface hex_scroller_if #(
  parameter int NUM_DIGITS = 6,
  parameter int NUM_CHARS  = 8,
  parameter int PW         = $clog2(NUM_CHARS)
);
  logic                    run;
  logic                    dir;
  logic                    step;
  logic                    load_en;
  logic [PW-1:0]           load_idx;
  logic [2:0]              load_char;
  logic [7*NUM_DIGITS-1:0] HEX;
  logic [PW-1:0]           pos;
  logic                    wrap;

  modport master (
    output run, dir, step, load_en, load_idx, load_char,
    input  HEX, pos, wrap
  );

  modport slave (
    input  run, dir, step, load_en, load_idx, load_char,
    output HEX, pos, wrap
  );
endinterface
`default_nettype wire

// File: rtl/hex_scroller.sv
`default_nettype none
//==============================================================================
// Module   : hex_scroller
// Brief    : Rotates a writable NUM_CHARS-character message across NUM_DIGITS
//            active-low seven-segment displays, on a timed tick or a step.
// Revision : 1.0
//==============================================================================
module hex_scroller #(
  parameter int NUM_DIGITS = 6,
  parameter int NUM_CHARS  = 8,
  parameter int TICK_DIV   = 50_000_000,
  parameter int PW         = $clog2(NUM_CHARS)
) (
  input  logic          CLOCK_50,
  input  logic          Resetn,
  hex_scroller_if.slave bus
);

  localparam int            CW          = $clog2(TICK_DIV);
  localparam logic [CW-1:0] C_TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [PW-1:0] C_POS_LAST  = PW'(NUM_CHARS - 1);

  localparam logic [2:0] C_CHR_D     = 3'd0;
  localparam logic [2:0] C_CHR_E     = 3'd1;
  localparam logic [2:0] C_CHR_ONE   = 3'd2;
  localparam logic [2:0] C_CHR_ZERO  = 3'd3;
  localparam logic [2:0] C_CHR_H     = 3'd4;
  localparam logic [2:0] C_CHR_L     = 3'd5;
  localparam logic [2:0] C_CHR_P     = 3'd6;
  localparam logic [2:0] C_CHR_BLANK = 3'd7;

  function automatic logic [6:0] f_seg(input logic [2:0] chr);
    case (chr)
      C_CHR_D:    f_seg = 7'h21;
      C_CHR_E:    f_seg = 7'h06;
      C_CHR_ONE:  f_seg = 7'h79;
      C_CHR_ZERO: f_seg = 7'h40;
      C_CHR_H:    f_seg = 7'h09;
      C_CHR_L:    f_seg = 7'h47;
      C_CHR_P:    f_seg = 7'h0C;
      default:    f_seg = 7'h7F;
    endcase
  endfunction

  function automatic logic [2:0] f_reset_char(input int slot);
    case (slot)
      0:       f_reset_char = C_CHR_D;
      1:       f_reset_char = C_CHR_E;
      2:       f_reset_char = C_CHR_ONE;
      default: f_reset_char = C_CHR_BLANK;
    endcase
  endfunction

  logic [CW-1:0]           r_tick_cnt;
  logic                    r_step_q;
  logic [PW-1:0]           r_pos;
  logic                    r_wrap_pend;
  logic                    r_wrap;
  logic [7*NUM_DIGITS-1:0] r_hex;
  logic [2:0]              r_msg [NUM_CHARS];

  logic                    w_tick;
  logic                    w_step_rise;
  logic                    w_advance;
  logic [7*NUM_DIGITS-1:0] w_hex_next;

  assign w_tick      = bus.run && (r_tick_cnt == C_TICK_LAST);
  assign w_step_rise = bus.step && !r_step_q;
  assign w_advance   = w_tick || w_step_rise;

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_tick_cnt <= '0;
      r_step_q   <= 1'b0;
    end else begin
      r_step_q <= bus.step;
      if (bus.run) begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
      end
    end
  end

  // wrap is staged one cycle so it lines up with the HEX refresh of the new pos
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_pos       <= '0;
      r_wrap_pend <= 1'b0;
      r_wrap      <= 1'b0;
    end else begin
      r_wrap      <= r_wrap_pend;
      r_wrap_pend <= 1'b0;
      if (w_advance) begin
        if (!bus.dir) begin
          if (r_pos == C_POS_LAST) begin
            r_pos       <= '0;
            r_wrap_pend <= 1'b1;
          end else begin
            r_pos <= r_pos + PW'(1);
          end
        end else begin
          if (r_pos == '0) begin
            r_pos       <= C_POS_LAST;
            r_wrap_pend <= 1'b1;
          end else begin
            r_pos <= r_pos - PW'(1);
          end
        end
      end
    end
  end

  // Only slots that exist can match, so out-of-range load_idx writes nothing
  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        r_msg[i] <= f_reset_char(i);
      end
    end else begin
      for (int i = 0; i < NUM_CHARS; i++) begin
        if (bus.load_en && (bus.load_idx == PW'(i))) begin
          r_msg[i] <= bus.load_char;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int OFS = NUM_DIGITS - 1 - k;
    logic [4:0]    w_sum;
    logic [PW-1:0] w_idx;
    assign w_sum = 5'(r_pos) + 5'(OFS);
    assign w_idx = PW'(w_sum % 5'(NUM_CHARS));
    assign w_hex_next[7*k +: 7] = f_seg(r_msg[w_idx]);
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      r_hex <= '1;
    end else begin
      r_hex <= w_hex_next;
    end
  end

  assign bus.HEX  = r_hex;
  assign bus.pos  = r_pos;
  assign bus.wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hex_scroller.sv
`default_nettype none
//==============================================================================
// Module   : tb_hex_scroller
// Brief    : Scoreboard bench for hex_scroller (8-char/6-digit and 9-char/4-digit).
// Revision : 1.0
//==============================================================================
module tb_hex_scroller;

  localparam int ND   = 6;
  localparam int NC   = 8;
  localparam int TDIV = 4;
  localparam int ND_B = 4;
  localparam int NC_B = 9;

  localparam logic [6:0]  SEG_TAB [8] = '{7'h21, 7'h06, 7'h79, 7'h40,
                                          7'h09, 7'h47, 7'h0C, 7'h7F};
  localparam logic [41:0] RESET_HEX   = {7'h21, 7'h06, 7'h79, 7'h7F, 7'h7F, 7'h7F};

  typedef struct packed {
    logic [2:0]  pos;
    logic [41:0] hex;
    logic        wrap;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hex_scroller_if #(.NUM_DIGITS(ND),   .NUM_CHARS(NC))   if_a ();
  hex_scroller_if #(.NUM_DIGITS(ND_B), .NUM_CHARS(NC_B)) if_b ();

  hex_scroller #(.NUM_DIGITS(ND), .NUM_CHARS(NC), .TICK_DIV(TDIV)) dut_a (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .bus      (if_a)
  );

  hex_scroller #(.NUM_DIGITS(ND_B), .NUM_CHARS(NC_B), .TICK_DIV(TDIV)) dut_b (
    .CLOCK_50 (clk),
    .Resetn   (rst_n),
    .bus      (if_b)
  );

  exp_t       sb [$];
  int         vectors     = 0;
  int         miscompares = 0;

  logic [2:0] m_msg [NC];
  int         m_pos;
  int         m_cnt;
  logic       m_stepq;
  logic       m_wrap_next;

  function automatic logic [41:0] hex_of(input int p);
    logic [41:0] h;
    h = '0;
    for (int k = 0; k < ND; k++) begin
      h[7*k +: 7] = SEG_TAB[m_msg[(p + ND - 1 - k) % NC]];
    end
    return h;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NC; i++) begin
      m_msg[i] = (i == 0) ? 3'd0 : (i == 1) ? 3'd1 : (i == 2) ? 3'd2 : 3'd7;
    end
    m_pos       = 0;
    m_cnt       = 0;
    m_stepq     = 1'b0;
    m_wrap_next = 1'b0;
  endfunction

  // Predicts the outputs seen after the coming edge, given current inputs.
  function automatic void model_edge();
    exp_t e;
    logic tick, adv, crossed;
    int   np;
    tick    = if_a.run && (m_cnt == TDIV - 1);
    adv     = tick || (if_a.step && !m_stepq);
    e.hex   = hex_of(m_pos);
    e.wrap  = m_wrap_next;
    np      = m_pos;
    crossed = 1'b0;
    if (adv) begin
      if (!if_a.dir) begin
        np      = (m_pos + 1) % NC;
        crossed = (m_pos == NC - 1);
      end else begin
        np      = (m_pos + NC - 1) % NC;
        crossed = (m_pos == 0);
      end
    end
    m_wrap_next = crossed;
    if (if_a.load_en) m_msg[if_a.load_idx] = if_a.load_char;
    if (if_a.run) m_cnt = tick ? 0 : m_cnt + 1;
    m_stepq = if_a.step;
    m_pos   = np;
    e.pos   = 3'(np);
    sb.push_back(e);
  endfunction

  task automatic cycle_a(output exp_t e);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if (if_a.HEX !== '1 || if_a.pos !== 3'd0 || if_a.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_a: hex=%h pos=%0d wrap=%b, required hex=all ones pos=0 wrap=0",
               if_a.HEX, if_a.pos, if_a.wrap);
    end
    vectors++;
    if (if_b.HEX !== '1 || if_b.pos !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_hold_b: hex=%h pos=%0d, required hex=all ones pos=0", if_b.HEX, if_b.pos);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle_a(e);
      vectors++;
      if (if_a.HEX !== RESET_HEX || if_a.pos !== 3'd0 || if_a.wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc %0d: hex=%h pos=%0d wrap=%b, required hex=%h pos=0 wrap=0",
                 i, if_a.HEX, if_a.pos, if_a.wrap, RESET_HEX);
      end
    end
  endtask

  task automatic test_auto_left();
    exp_t e;
    if_a.dir = 1'b0;
    if_a.run = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      cycle_a(e);
      vectors++;
      if (if_a.pos !== e.pos || if_a.HEX !== e.hex || if_a.wrap !== e.wrap) begin
        miscompares++;
        $display("FAIL auto_left_model cyc %0d: pos=%0d hex=%h wrap=%b, expected pos=%0d hex=%h wrap=%b",
                 i, if_a.pos, if_a.HEX, if_a.wrap, e.pos, e.hex, e.wrap);
      end
      vectors++;
      if (if_a.pos !== 3'((i / TDIV) % NC) || if_a.wrap !== 1'(i == 33)) begin
        miscompares++;
        $display("FAIL auto_left_seq cyc %0d: pos=%0d wrap=%b, expected pos=%0d wrap=%0d",
                 i, if_a.pos, if_a.wrap, (i / TDIV) % NC, (i == 33));
      end
      if (i == TDIV + 1) begin
        vectors++;
        if (if_a.HEX[41:35] !== 7'h06) begin
          miscompares++;
          $display("FAIL auto_left_hex5: hex5=%h, expected 06", if_a.HEX[41:35]);
        end
      end
    end
  endtask

  // Entered with the interval counter at 2.
  task automatic test_freeze_resume();
    exp_t       e;
    logic [2:0] p0;
    if_a.run = 1'b0;
    p0 = if_a.pos;
    for (int i = 0; i < 20; i++) begin
      cycle_a(e);
      vectors++;
      if (if_a.pos !== p0 || if_a.HEX !== e.hex || if_a.wrap !== e.wrap) begin
        miscompares++;
        $display("FAIL freeze_hold cyc %0d: pos=%0d hex=%h, expected pos=%0d hex=%h",
                 i, if_a.pos, if_a.HEX, p0, e.hex);
      end
    end
    if_a.run = 1'b1;
    cycle_a(e);
    vectors++;
    if (if_a.pos !== p0) begin
      miscompares++;
      $display("FAIL resume_early: pos=%0d, expected %0d", if_a.pos, p0);
    end
    cycle_a(e);
    vectors++;
    if (if_a.pos !== p0 + 3'd1 || if_a.pos !== e.pos) begin
      miscompares++;
      $display("FAIL resume_advance: pos=%0d, expected %0d", if_a.pos, p0 + 3'd1);
    end
    if_a.run = 1'b0;
    cycle_a(e);
    vectors++;
    if (if_a.HEX !== e.hex || if_a.wrap !== e.wrap) begin
      miscompares++;
      $display("FAIL resume_hex: hex=%h wrap=%b, expected hex=%h wrap=%b", if_a.HEX, if_a.wrap, e.hex, e.wrap);
    end
  endtask

  task automatic test_right_wrap();
    exp_t e;
    int   wraps;
    wraps    = 0;
    if_a.dir = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 4; c++) begin
        if_a.step = (c == 0);
        cycle_a(e);
        vectors++;
        if (if_a.pos !== e.pos || if_a.HEX !== e.hex || if_a.wrap !== e.wrap) begin
          miscompares++;
          $display("FAIL right_model p%0d c%0d: pos=%0d hex=%h wrap=%b, expected pos=%0d hex=%h wrap=%b",
                   p, c, if_a.pos, if_a.HEX, if_a.wrap, e.pos, e.hex, e.wrap);
        end
        if (p == 1) wraps += int'(if_a.wrap);
      end
    end
    if_a.step = 1'b0;
    vectors++;
    if (wraps != 1 || if_a.pos !== 3'd7) begin
      miscompares++;
      $display("FAIL right_wrap: wrap pulses=%0d pos=%0d, expected 1 pulse pos=7", wraps, if_a.pos);
    end
    vectors++;
    if (if_a.HEX[41:35] !== 7'h7F || if_a.HEX[34:28] !== 7'h21) begin
      miscompares++;
      $display("FAIL right_hex: hex5=%h hex4=%h, expected 7f 21", if_a.HEX[41:35], if_a.HEX[34:28]);
    end
  endtask

  task automatic test_collision();
    exp_t       e;
    logic [2:0] p0;
    if_a.dir = 1'b0;
    if_a.run = 1'b1;
    for (int g = 0; g < TDIV && m_cnt != TDIV - 1; g++) begin
      cycle_a(e);
      vectors++;
      if (if_a.pos !== e.pos || if_a.HEX !== e.hex) begin
        miscompares++;
        $display("FAIL collide_pre: pos=%0d hex=%h, expected pos=%0d hex=%h", if_a.pos, if_a.HEX, e.pos, e.hex);
      end
    end
    p0 = if_a.pos;
    if_a.step = 1'b1;
    cycle_a(e);
    if_a.run = 1'b0;
    vectors++;
    if (if_a.pos !== p0 + 3'd1 || if_a.pos !== e.pos) begin
      miscompares++;
      $display("FAIL collide_once: pos=%0d, expected %0d", if_a.pos, p0 + 3'd1);
    end
    for (int i = 0; i < 10; i++) begin
      cycle_a(e);
      vectors++;
      if (if_a.pos !== p0 + 3'd1 || if_a.HEX !== e.hex || if_a.wrap !== e.wrap) begin
        miscompares++;
        $display("FAIL step_hold cyc %0d: pos=%0d hex=%h wrap=%b, expected pos=%0d hex=%h wrap=%b",
                 i, if_a.pos, if_a.HEX, if_a.wrap, p0 + 3'd1, e.hex, e.wrap);
      end
    end
    if_a.step = 1'b0;
    cycle_a(e);
  endtask

  task automatic test_load_during_run();
    exp_t       e;
    logic [2:0] p0;
    int         off;
    if_a.dir = 1'b0;
    if_a.run = 1'b1;
    for (int g = 0; g < TDIV && m_cnt != TDIV - 1; g++) cycle_a(e);
    p0 = if_a.pos;
    if_a.load_en   = 1'b1;
    if_a.load_idx  = 3'd3;
    if_a.load_char = 3'd4;
    cycle_a(e);
    if_a.load_en = 1'b0;
    if_a.run     = 1'b0;
    vectors++;
    if (if_a.pos !== p0 + 3'd1) begin
      miscompares++;
      $display("FAIL load_adv: pos=%0d, expected %0d", if_a.pos, p0 + 3'd1);
    end
    cycle_a(e);
    vectors++;
    if (if_a.HEX !== e.hex) begin
      miscompares++;
      $display("FAIL load_model: hex=%h, expected %h", if_a.HEX, e.hex);
    end
    off = (3 - int'(if_a.pos) + NC) % NC;
    if (off < ND) begin
      vectors++;
      if (if_a.HEX[7*(ND-1-off) +: 7] !== 7'h09) begin
        miscompares++;
        $display("FAIL load_h: digit %0d=%h, expected 09", ND - 1 - off, if_a.HEX[7*(ND-1-off) +: 7]);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    if_a.run = 1'b1;
    repeat (5) cycle_a(e);
    rst_n    = 1'b0;
    if_a.run = 1'b0;
    #1;
    vectors++;
    if (if_a.HEX !== '1 || if_a.pos !== 3'd0 || if_a.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: hex=%h pos=%0d wrap=%b, required all ones/0/0", if_a.HEX, if_a.pos, if_a.wrap);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle_a(e);
      vectors++;
      if (if_a.HEX !== RESET_HEX || if_a.pos !== 3'd0 || if_a.HEX !== e.hex) begin
        miscompares++;
        $display("FAIL reset_mid_after cyc %0d: hex=%h pos=%0d, required hex=%h pos=0",
                 i, if_a.HEX, if_a.pos, RESET_HEX);
      end
    end
  endtask

  task automatic test_nonpow2();
    if_b.load_en   = 1'b1;
    if_b.load_idx  = 4'd9;
    if_b.load_char = 3'd4;
    @(posedge clk); @(negedge clk);
    if_b.load_idx  = 4'd8;
    if_b.load_char = 3'd6;
    @(posedge clk); @(negedge clk);
    if_b.load_en = 1'b0;
    @(posedge clk); @(negedge clk);
    vectors++;
    if (if_b.HEX !== {7'h21, 7'h06, 7'h79, 7'h7F} || if_b.pos !== 4'd0) begin
      miscompares++;
      $display("FAIL b_ignore_idx9: hex=%h pos=%0d, expected 21067 9/7f pos=0 -> %h", if_b.HEX, if_b.pos,
               {7'h21, 7'h06, 7'h79, 7'h7F});
    end
    for (int s = 1; s <= 8; s++) begin
      if_b.step = 1'b1;
      @(posedge clk); @(negedge clk);
      if_b.step = 1'b0;
      vectors++;
      if (if_b.pos !== 4'(s) || if_b.wrap !== 1'b0) begin
        miscompares++;
        $display("FAIL b_step %0d: pos=%0d wrap=%b, expected pos=%0d wrap=0", s, if_b.pos, if_b.wrap, s);
      end
      @(posedge clk); @(negedge clk);
    end
    vectors++;
    if (if_b.HEX !== {7'h0C, 7'h21, 7'h06, 7'h79}) begin
      miscompares++;
      $display("FAIL b_mod_map: hex=%h, expected %h", if_b.HEX, {7'h0C, 7'h21, 7'h06, 7'h79});
    end
    if_b.step = 1'b1;
    @(posedge clk); @(negedge clk);
    if_b.step = 1'b0;
    vectors++;
    if (if_b.pos !== 4'd0 || if_b.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL b_wrap_pos: pos=%0d wrap=%b, expected pos=0 wrap=0", if_b.pos, if_b.wrap);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (if_b.wrap !== 1'b1 || if_b.HEX !== {7'h21, 7'h06, 7'h79, 7'h7F}) begin
      miscompares++;
      $display("FAIL b_wrap_pulse: wrap=%b hex=%h, expected wrap=1 hex=%h", if_b.wrap, if_b.HEX,
               {7'h21, 7'h06, 7'h79, 7'h7F});
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (if_b.wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL b_wrap_len: wrap=%b, expected 0", if_b.wrap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    if_a.run = 1'b0; if_a.dir = 1'b0; if_a.step = 1'b0;
    if_a.load_en = 1'b0; if_a.load_idx = '0; if_a.load_char = '0;
    if_b.run = 1'b0; if_b.dir = 1'b0; if_b.step = 1'b0;
    if_b.load_en = 1'b0; if_b.load_idx = '0; if_b.load_char = '0;
    test_reset();
    test_auto_left();
    test_freeze_resume();
    test_right_wrap();
    test_collision();
    test_load_during_run();
    test_reset_mid();
    test_nonpow2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
